decode_hold_ctrl: RTL and testbench
===================================

Name: decode_hold_ctrl

Overview:
- Sequences the external hold and wakeup inputs of the decode stage.
- Provides debug halt/resume/single-step, sleep until an event or timeout, and wakeup pulse generation.
- Merges the data-hazard, fetch and external holds into the final decode hold.
- Counts stalled cycles for performance monitoring. Sits beside decode, between the debug/event logic and the pipeline control signals.

Parameters:
CNT_W, 32, width of the stall cycle counter
TO_W, 16, width of the sleep timeout counter
SLEEP_TIMEOUT, 0, cycles in SLEEP before automatic wake; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
halt_req  in  1  single-cycle pulse, debug halt request
resume  in  1  single-cycle pulse, leave HALTED
step  in  1  single-cycle pulse, execute one instruction while HALTED
sleep_req  in  1  single-cycle pulse from decode (wait/sleep instruction)
wake_evt  in  1  level, pending event/interrupt
hold_data  in  1  hold from data hazard control
hold_if  in  1  hold from instruction fetch
ready_ls  in  1  load/store unit idle
stall_cnt_clr  in  1  synchronous clear of stall_cnt
hold_ext  out  1  registered external hold
hold  out  1  hold_data | hold_if | hold_ext (combinational)
wakeup  out  1  registered single-cycle wake pulse to decode
halted  out  1  registered, high only in HALTED
sleeping  out  1  registered, high only in SLEEP
stall_cnt  out  CNT_W  saturating count of cycles with hold=1

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low. During reset the state is RUN and all outputs are 0, including stall_cnt and the timeout counter.
- Output registers: hold_ext, wakeup, halted and sleeping are decoded from the next state and registered. They take effect one cycle after the triggering input.
- States: RUN, DRAIN, HALTED, STEP, SLEEP, WAKE.
- RUN (hold_ext=0):
  - halt_req -> DRAIN.
  - Otherwise sleep_req -> SLEEP.
  - halt_req has priority over sleep_req.
- DRAIN (hold_ext=1): stays until ready_ls=1, then -> HALTED. If ready_ls=1 on entry, DRAIN lasts exactly 1 cycle.
- HALTED (hold_ext=1, halted=1):
  - resume -> RUN.
  - Otherwise step -> STEP.
  - resume has priority over step. halt_req is ignored here.
- STEP (hold_ext=0):
  - Stays while hold_data|hold_if=1.
  - The first cycle with hold_data|hold_if=0 is the advance cycle; -> DRAIN.
  - Exactly one instruction passes decode.
  - halt_req is ignored; resume here -> RUN.
- SLEEP (hold_ext=1, sleeping=1):
  - halt_req -> DRAIN, sleeping drops, and no wakeup pulse is produced.
  - Otherwise wake_evt=1 -> WAKE.
  - Otherwise, with SLEEP_TIMEOUT≠0, the timeout counter reaching SLEEP_TIMEOUT-1 -> WAKE, giving exactly SLEEP_TIMEOUT cycles with sleeping=1.
  - If wake_evt is already high on entry, SLEEP lasts 1 cycle.
- WAKE (hold_ext=0, wakeup=1): lasts exactly 1 cycle, then -> RUN. sleep_req in WAKE is ignored.
- Ignored pulses: resume/step outside HALTED/STEP and sleep_req outside RUN are ignored. Pulses are not queued.
- Timeout counter: cleared on SLEEP entry, increments each SLEEP cycle, TO_W bits wide. SLEEP_TIMEOUT must be < 2^TO_W; a static assertion enforces this.
- stall_cnt:
  - +1 in each cycle with hold=1, saturating at all-ones.
  - stall_cnt_clr has priority: it zeroes the counter and that cycle is not counted.
- hold updates combinationally with hold_data/hold_if. No combinational path exists from halt_req/resume/step/sleep_req/wake_evt to any output.
- Reset mid-operation: any state returns to RUN asynchronously. hold_ext and wakeup drop immediately, so no stale wakeup pulse occurs after reset release.

Decomposition:
- Pu_types gets typedef enum Hold_ctrl_state {HC_RUN, HC_DRAIN, HC_HALTED, HC_STEP, HC_SLEEP, HC_WAKE}.
- One sub-module: sat_counter (parameter W; ports clk, reset, clr, inc, value), instanced for stall_cnt. It is reusable elsewhere.
- Timeout counter stays inline.

Test Plan:
- Reset then idle 10 cycles with hold_data=hold_if=0 -> hold=0, hold_ext=0, stall_cnt=0, halted=0. Assert reset mid-SLEEP -> sleeping=0 and wakeup=0 immediately.
- halt_req at cycle 5, ready_ls=0 until cycle 9 -> hold_ext=1 from cycle 6, halted=1 from cycle 10. resume at cycle 15 -> hold_ext=0, halted=0 at cycle 16.
- While HALTED, step with hold_data=1 for 3 cycles -> hold_ext=0 for 4 cycles, exactly one cycle with hold=0, then DRAIN and halted re-asserts. step+resume in the same cycle -> RUN.
- sleep_req, wake_evt rises 7 cycles later -> sleeping=1 for 7 cycles, then wakeup=1 for exactly 1 cycle, then RUN. sleep_req with wake_evt already 1 -> sleeping for 1 cycle.
- SLEEP_TIMEOUT=4, sleep_req, wake_evt=0 -> sleeping=1 for exactly 4 cycles, then a wakeup pulse. halt_req during SLEEP with wake_evt=1 in the same cycle -> DRAIN, no wakeup pulse.
- CNT_W=4, hold_data=1 for 20 cycles -> stall_cnt saturates at 15. stall_cnt_clr while hold=1 -> 0 that cycle, 1 the next cycle.

Source files
------------

// File: rtl/decode_hold_ctrl_pkg.sv
// Shared types for the decode hold controller.
// State encoding, registered output bundle and its state decoder.
package decode_hold_ctrl_pkg;

  typedef enum logic [2:0] {
    HC_RUN,
    HC_DRAIN,
    HC_HALTED,
    HC_STEP,
    HC_SLEEP,
    HC_WAKE
  } hold_ctrl_state_e;

  typedef struct packed {
    logic hold_ext;
    logic wakeup;
    logic halted;
    logic sleeping;
  } hc_out_t;

  function automatic hc_out_t hc_decode(
    input hold_ctrl_state_e s
  );
    hc_out_t o;
    o = '0;
    unique case (s)
      HC_DRAIN: o.hold_ext = 1'b1;
      HC_HALTED: begin
        o.hold_ext = 1'b1;
        o.halted   = 1'b1;
      end
      HC_SLEEP: begin
        o.hold_ext = 1'b1;
        o.sleeping = 1'b1;
      end
      HC_WAKE: o.wakeup = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/decode_hold_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clr beats inc).
// Ports: clk, reset (async active-low), clr, inc, value[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/decode_hold_ctrl.sv
// Decode hold sequencer: debug halt/step, sleep/wake, hold merge.
// Ports: pulses halt_req/resume/step/sleep_req, levels wake_evt,
// hold_data, hold_if, ready_ls, stall_cnt_clr; outputs hold_ext,
// hold, wakeup, halted, sleeping, stall_cnt[CNT_W-1:0].
module decode_hold_ctrl
  import decode_hold_ctrl_pkg::*;
#(
  parameter int CNT_W         = 32,
  parameter int TO_W          = 16,
  parameter int SLEEP_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_req,
  input  logic             resume,
  input  logic             step,
  input  logic             sleep_req,
  input  logic             wake_evt,
  input  logic             hold_data,
  input  logic             hold_if,
  input  logic             ready_ls,
  input  logic             stall_cnt_clr,
  output logic             hold_ext,
  output logic             hold,
  output logic             wakeup,
  output logic             halted,
  output logic             sleeping,
  output logic [CNT_W-1:0] stall_cnt
);

  if ((SLEEP_TIMEOUT < 0) ||
      (longint'(SLEEP_TIMEOUT) >= (longint'(1) << TO_W)))
  begin : g_to_range
    $error("SLEEP_TIMEOUT does not fit in TO_W bits");
  end

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((SLEEP_TIMEOUT > 0) ? SLEEP_TIMEOUT - 1 : 0);

  hold_ctrl_state_e state;
  hold_ctrl_state_e nxt;
  hc_out_t          out_q;
  logic [TO_W-1:0]  to_cnt;
  logic             hold_pipe;
  logic             to_hit;

  assign hold_pipe = hold_data | hold_if;
  assign to_hit    = (SLEEP_TIMEOUT != 0) &&
                     (to_cnt == TO_LAST);

  always_comb begin
    nxt = state;
    unique case (state)
      HC_RUN: begin
        if (halt_req)       nxt = HC_DRAIN;
        else if (sleep_req) nxt = HC_SLEEP;
      end
      HC_DRAIN: begin
        if (ready_ls) nxt = HC_HALTED;
      end
      HC_HALTED: begin
        if (resume)    nxt = HC_RUN;
        else if (step) nxt = HC_STEP;
      end
      HC_STEP: begin
        // the first unheld cycle lets one instruction through
        if (resume)          nxt = HC_RUN;
        else if (!hold_pipe) nxt = HC_DRAIN;
      end
      HC_SLEEP: begin
        // halt wins: go straight to drain, no wake pulse
        if (halt_req)      nxt = HC_DRAIN;
        else if (wake_evt) nxt = HC_WAKE;
        else if (to_hit)   nxt = HC_WAKE;
      end
      HC_WAKE: nxt = HC_RUN;
      default: nxt = HC_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= HC_RUN;
      out_q  <= '0;
      to_cnt <= '0;
    end else begin
      state <= nxt;
      out_q <= hc_decode(nxt);
      // idle at zero outside SLEEP, so entry always starts at 0
      if (state != HC_SLEEP) to_cnt <= '0;
      else                   to_cnt <= to_cnt + TO_W'(1);
    end
  end

  assign hold_ext = out_q.hold_ext;
  assign wakeup   = out_q.wakeup;
  assign halted   = out_q.halted;
  assign sleeping = out_q.sleeping;
  assign hold     = hold_pipe | out_q.hold_ext;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (stall_cnt_clr),
    .inc  (hold),
    .value(stall_cnt)
  );

  a_halt_sleep_excl: assert property (
    @(posedge clk) disable iff (!reset)
    !(halted && sleeping));

  a_wake_no_hold: assert property (
    @(posedge clk) disable iff (!reset)
    !(wakeup && hold_ext));

endmodule

// File: tb/tb_decode_hold_ctrl.sv
// Scoreboard bench for decode_hold_ctrl.
// Stimulus queues expected outputs; a negedge monitor compares them.
module tb_decode_hold_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic halt_req = 1'b0, resume = 1'b0, step = 1'b0;
  logic sleep_req = 1'b0, wake_evt = 1'b0;
  logic hold_data = 1'b0, hold_if = 1'b0;
  logic ready_ls = 1'b0, stall_cnt_clr = 1'b0;

  logic hold_ext, hold, wakeup, halted, sleeping;
  logic [3:0] stall_cnt;
  logic t_hold_ext, t_hold, t_wakeup, t_halted, t_sleeping;
  logic [31:0] t_stall_cnt;

  always #5 clk = ~clk;

  decode_hold_ctrl #(
    .CNT_W(4), .TO_W(16), .SLEEP_TIMEOUT(0)
  ) dut (
    .clk(clk), .reset(reset),
    .halt_req(halt_req), .resume(resume), .step(step),
    .sleep_req(sleep_req), .wake_evt(wake_evt),
    .hold_data(hold_data), .hold_if(hold_if),
    .ready_ls(ready_ls), .stall_cnt_clr(stall_cnt_clr),
    .hold_ext(hold_ext), .hold(hold), .wakeup(wakeup),
    .halted(halted), .sleeping(sleeping),
    .stall_cnt(stall_cnt)
  );

  decode_hold_ctrl #(
    .CNT_W(32), .TO_W(16), .SLEEP_TIMEOUT(4)
  ) dut_to (
    .clk(clk), .reset(reset),
    .halt_req(halt_req), .resume(resume), .step(step),
    .sleep_req(sleep_req), .wake_evt(wake_evt),
    .hold_data(hold_data), .hold_if(hold_if),
    .ready_ls(ready_ls), .stall_cnt_clr(stall_cnt_clr),
    .hold_ext(t_hold_ext), .hold(t_hold), .wakeup(t_wakeup),
    .halted(t_halted), .sleeping(t_sleeping),
    .stall_cnt(t_stall_cnt)
  );

  // pulse masks {halt_req, resume, step, sleep_req, stall_cnt_clr}
  localparam logic [4:0] P_NONE  = 5'b00000;
  localparam logic [4:0] P_HALT  = 5'b10000;
  localparam logic [4:0] P_RES   = 5'b01000;
  localparam logic [4:0] P_STEP  = 5'b00100;
  localparam logic [4:0] P_SLEEP = 5'b00010;
  localparam logic [4:0] P_CLR   = 5'b00001;

  // expected v = {hold_ext, hold, wakeup, halted, sleeping}
  typedef struct {
    string      tag;
    logic [4:0] v;
    int         c;
    bit         sel;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   use_to = 1'b0;

  logic lv_rst = 1'b0, lv_wake = 1'b0;
  logic lv_hd = 1'b0, lv_hi = 1'b0, lv_rdy = 1'b0;

  exp_t       mon_e;
  logic [4:0] mon_got;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_got = mon_e.sel ?
        {t_hold_ext, t_hold, t_wakeup, t_halted, t_sleeping} :
        {hold_ext, hold, wakeup, halted, sleeping};
      n_chk++;
      if (mon_got !== mon_e.v) begin
        n_fail++;
        $display("FAIL %s: outs got %b want %b",
                 mon_e.tag, mon_got, mon_e.v);
      end
      if (mon_e.c >= 0) begin
        n_chk++;
        if (stall_cnt !== 4'(mon_e.c)) begin
          n_fail++;
          $display("FAIL %s_cnt: stall_cnt got %0d want %0d",
                   mon_e.tag, stall_cnt, mon_e.c);
        end
      end
    end
  end

  task automatic cyc(input logic [4:0] p, input logic [4:0] v,
                     input int c, input string tag);
    exp_t e;
    @(negedge clk);
    #1;
    {reset, wake_evt, hold_data, hold_if, ready_ls} =
      {lv_rst, lv_wake, lv_hd, lv_hi, lv_rdy};
    {halt_req, resume, step, sleep_req, stall_cnt_clr} = p;
    e.tag = tag;
    e.v   = v;
    e.c   = c;
    e.sel = use_to;
    sb.push_back(e);
  endtask

  task automatic chk(input string tag, input logic got,
                     input logic want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1;
    reset = 1'b0;
    lv_rst = 1'b0;
    lv_wake = 1'b0;
    wake_evt = 1'b0;
    {halt_req, resume, step, sleep_req, stall_cnt_clr} = P_NONE;
    #1;
    chk("rst_sleeping", sleeping, 1'b0);
    chk("rst_wakeup", wakeup, 1'b0);
    chk("rst_hold_ext", hold_ext, 1'b0);
  endtask

  initial begin
    repeat (3) cyc(P_NONE, 5'b00000, 0, "reset");
    lv_rst = 1'b1;
    repeat (10) cyc(P_NONE, 5'b00000, 0, "idle");
    cyc(P_RES, 5'b00000, 0, "run_resume_ign");
    cyc(P_STEP, 5'b00000, 0, "run_step_ign");

    // halt with slow load/store drain
    cyc(P_HALT, 5'b11000, 0, "drain_enter");
    cyc(P_NONE, 5'b11000, 1, "drain_wait");
    cyc(P_NONE, 5'b11000, 2, "drain_wait");
    lv_rdy = 1'b1;
    cyc(P_NONE, 5'b11010, 3, "halted");
    for (int i = 4; i <= 6; i++)
      cyc(P_NONE, 5'b11010, i, "halted_idle");
    cyc(P_RES, 5'b00000, 7, "resume");
    cyc(P_NONE, 5'b00000, 7, "run_after_resume");
    cyc(P_CLR, 5'b00000, 0, "clr");

    // single step with 3 held cycles
    cyc(P_HALT, 5'b11000, 0, "drain2");
    cyc(P_NONE, 5'b11010, 1, "halted2");
    cyc(P_STEP, 5'b00000, 2, "step_enter");
    lv_hd = 1'b1;
    for (int i = 3; i <= 5; i++)
      cyc(P_NONE, 5'b01000, i, "step_hold");
    lv_hd = 1'b0;
    cyc(P_NONE, 5'b11000, 5, "step_advance");
    cyc(P_NONE, 5'b11010, 6, "step_rehalt");
    cyc(P_HALT, 5'b11010, 7, "halted_halt_ign");
    cyc(P_STEP | P_RES, 5'b00000, 8, "step_resume_prio");
    cyc(P_NONE, 5'b00000, 8, "run3");
    cyc(P_CLR, 5'b00000, 0, "clr2");

    // resume while stepping
    cyc(P_HALT, 5'b11000, 0, "drain3");
    cyc(P_NONE, 5'b11010, 1, "halted3");
    lv_hd = 1'b1;
    cyc(P_STEP, 5'b01000, 2, "step3");
    cyc(P_RES, 5'b01000, 3, "step_resume");
    lv_hd = 1'b0;
    cyc(P_NONE, 5'b00000, 3, "run4");
    cyc(P_CLR, 5'b00000, 0, "clr3");

    // sleep, event 7 cycles later
    cyc(P_SLEEP, 5'b11001, 0, "sleep_enter");
    for (int i = 1; i <= 6; i++)
      cyc(P_NONE, 5'b11001, i, "sleeping");
    lv_wake = 1'b1;
    cyc(P_NONE, 5'b00100, 7, "wake_pulse");
    lv_wake = 1'b0;
    cyc(P_SLEEP, 5'b00000, 7, "wake_sleep_ign");
    cyc(P_NONE, 5'b00000, 7, "run5");

    // event already pending on entry
    lv_wake = 1'b1;
    cyc(P_SLEEP, 5'b11001, 7, "sleep_wake_hi");
    cyc(P_NONE, 5'b00100, 8, "wake_pulse2");
    lv_wake = 1'b0;
    cyc(P_NONE, 5'b00000, 8, "run6");
    cyc(P_CLR, 5'b00000, 0, "clr4");

    // halt beats wake while sleeping
    cyc(P_SLEEP, 5'b11001, 0, "sleep3");
    lv_wake = 1'b1;
    lv_rdy = 1'b0;
    cyc(P_HALT, 5'b11000, 1, "sleep_halt");
    lv_wake = 1'b0;
    lv_rdy = 1'b1;
    cyc(P_NONE, 5'b11010, 2, "halted4");
    cyc(P_RES, 5'b00000, 3, "resume4");
    cyc(P_CLR, 5'b00000, 0, "clr5");

    // saturation and clear priority
    lv_hd = 1'b1;
    for (int i = 1; i <= 20; i++)
      cyc(P_NONE, 5'b01000, (i > 15) ? 15 : i, "stall_sat");
    cyc(P_CLR, 5'b01000, 0, "clr_hold");
    cyc(P_NONE, 5'b01000, 1, "cnt_after_clr");
    lv_hd = 1'b0;
    cyc(P_NONE, 5'b00000, 1, "hold_drop");
    lv_hi = 1'b1;
    cyc(P_NONE, 5'b01000, 2, "hold_if");
    lv_hi = 1'b0;
    cyc(P_NONE, 5'b00000, 2, "hold_if_drop");

    // sleep timeout on the SLEEP_TIMEOUT=4 instance
    lv_rst = 1'b0;
    cyc(P_NONE, 5'b00000, 0, "reset2");
    use_to = 1'b1;
    lv_rst = 1'b1;
    cyc(P_NONE, 5'b00000, -1, "to_idle");
    cyc(P_SLEEP, 5'b11001, -1, "to_sleep");
    repeat (3) cyc(P_NONE, 5'b11001, -1, "to_sleeping");
    cyc(P_NONE, 5'b00100, -1, "to_wake");
    cyc(P_NONE, 5'b00000, -1, "to_run");
    cyc(P_NONE, 5'b00000, -1, "to_run2");
    use_to = 1'b0;

    // asynchronous reset in SLEEP and in WAKE
    lv_rst = 1'b0;
    cyc(P_NONE, 5'b00000, 0, "reset3");
    lv_rst = 1'b1;
    cyc(P_NONE, 5'b00000, 0, "rel3");
    cyc(P_SLEEP, 5'b11001, 0, "sleep4");
    async_reset();
    cyc(P_NONE, 5'b00000, 0, "in_reset");
    lv_rst = 1'b1;
    cyc(P_NONE, 5'b00000, 0, "rel4");
    cyc(P_SLEEP, 5'b11001, 0, "sleep5");
    lv_wake = 1'b1;
    cyc(P_NONE, 5'b00100, 1, "wake5");
    async_reset();
    cyc(P_NONE, 5'b00000, 0, "in_reset2");
    lv_rst = 1'b1;
    cyc(P_NONE, 5'b00000, 0, "rel5");
    cyc(P_NONE, 5'b00000, 0, "no_stale_wake");

    repeat (2) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_sb: left %0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
